// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the runtime-configurable clock divider (clk_div_cfg).
package clk_div_pkg;

  typedef enum logic [1:0] {IDLE, RUN, BYPASS, DRAIN} state_t;

  localparam int unsigned BYPASS_MAX_RATIO = 1;

  // Number of ref_clk cycles the divided clock spends high in one period.
  function automatic int unsigned high_len(input int unsigned ratio);
    return ratio >> 1;
  endfunction

endpackage

// File: rtl/clk_glitchfree_mux.sv
// Negedge-side output stage of clk_div_cfg: bypass select flop and the divided clock mux.
// CLK_DIV_ODD_DUTY50_EN adds a negedge copy of div_q to stretch odd ratios to 50% duty.
module clk_glitchfree_mux (
  input  logic ref_clk,
  input  logic reset,
  input  logic div_q,
  input  logic bypass_req,
  input  logic odd_ratio,
  output logic divided_clk,
  output logic bypass_active
);

  logic bypass_q;
  logic div_path;

  // Switching only while ref_clk is low and div_q is low means neither source is high at the swap.
  always_ff @(negedge ref_clk or negedge reset) begin
    if (!reset) begin
      bypass_q <= 1'b0;
    end else if (!bypass_req) begin
      bypass_q <= 1'b0;
    end else if (!div_q) begin
      bypass_q <= 1'b1;
    end
  end

`ifdef CLK_DIV_ODD_DUTY50_EN
  logic div_q_neg;

  always_ff @(negedge ref_clk or negedge reset) begin
    if (!reset) begin
      div_q_neg <= 1'b0;
    end else begin
      div_q_neg <= div_q;
    end
  end

  assign div_path = div_q | (div_q_neg & odd_ratio);
`else
  logic unused_odd;
  assign unused_odd = odd_ratio;
  assign div_path   = div_q;
`endif

  assign divided_clk   = bypass_q ? ref_clk : div_path;
  assign bypass_active = bypass_q;

endmodule

// File: rtl/clk_div_cfg.sv
// Runtime-reconfigurable integer clock divider with glitch-free bypass and graceful stop.
// Optional odd-ratio 50% duty is selected with CLK_DIV_ODD_DUTY50_EN.
module clk_div_cfg #(
  parameter int RATIO_W = 8
) (
  input  logic               ref_clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [RATIO_W-1:0] division_ratio,
  output logic               divided_clk,
  output logic               div_tick,
  output logic [RATIO_W-1:0] ratio_active,
  output logic               bypass_active
);

  import clk_div_pkg::*;

  state_t             state;
  logic [RATIO_W-1:0] counter;
  logic [RATIO_W-1:0] next_cnt;
  logic [RATIO_W-1:0] high;
  logic               div_q;
  logic               bypass_req;
  logic               ratio_ge2;
  logic               boundary;

  assign ratio_ge2 = division_ratio > RATIO_W'(BYPASS_MAX_RATIO);
  assign high      = RATIO_W'(high_len(32'(ratio_active)));
  assign next_cnt  = counter + RATIO_W'(1);
  assign boundary  = counter == (ratio_active - RATIO_W'(1));

  // ratio_active doubles as the shadow ratio; it only changes at period boundaries in divide mode.
  always_ff @(posedge ref_clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      counter      <= '0;
      div_q        <= 1'b0;
      div_tick     <= 1'b0;
      ratio_active <= '0;
      bypass_req   <= 1'b0;
    end else begin
      div_tick <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            ratio_active <= division_ratio;
            if (ratio_ge2) begin
              state    <= RUN;
              counter  <= '0;
              div_q    <= 1'b1;
              div_tick <= 1'b1;
            end else begin
              state      <= BYPASS;
              bypass_req <= 1'b1;
            end
          end
        end
        RUN, DRAIN: begin
          if (boundary) begin
            counter <= '0;
            if (!enable) begin
              state        <= IDLE;
              div_q        <= 1'b0;
              ratio_active <= '0;
            end else if (!ratio_ge2) begin
              state        <= BYPASS;
              bypass_req   <= 1'b1;
              div_q        <= 1'b0;
              ratio_active <= division_ratio;
            end else begin
              state        <= RUN;
              div_q        <= 1'b1;
              div_tick     <= 1'b1;
              ratio_active <= division_ratio;
            end
          end else begin
            counter <= next_cnt;
            div_q   <= next_cnt < high;
            state   <= enable ? RUN : DRAIN;
          end
        end
        BYPASS: begin
          // Leaving takes two steps: drop the request, let the negedge flop clear, then move on.
          ratio_active <= division_ratio;
          if (bypass_req) begin
            if (!enable || ratio_ge2) begin
              bypass_req <= 1'b0;
            end
          end else if (!enable) begin
            state        <= IDLE;
            ratio_active <= '0;
          end else if (ratio_ge2) begin
            state    <= RUN;
            counter  <= '0;
            div_q    <= 1'b1;
            div_tick <= 1'b1;
          end else begin
            bypass_req <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  clk_glitchfree_mux u_mux (
    .ref_clk       (ref_clk),
    .reset         (reset),
    .div_q         (div_q),
    .bypass_req    (bypass_req),
    .odd_ratio     (ratio_active[0]),
    .divided_clk   (divided_clk),
    .bypass_active (bypass_active)
  );

endmodule

// File: tb/tb_clk_div_cfg.sv
// Self-checking bench for clk_div_cfg: directed scenarios plus randomized enable/ratio traffic.
// Honours CLK_DIV_ODD_DUTY50_EN when predicting odd-ratio waveforms.
module tb_clk_div_cfg;

  localparam int HALF = 5;
  localparam int M_OFF = 0, M_DIV = 1, M_BYP = 2, M_LEAVE = 3;

`ifdef CLK_DIV_ODD_DUTY50_EN
  localparam bit DUTY50 = 1'b1;
`else
  localparam bit DUTY50 = 1'b0;
`endif

  logic       ref_clk;
  logic       reset;
  logic       enable;
  logic [7:0] division_ratio;
  logic       divided_clk;
  logic       div_tick;
  logic [7:0] ratio_active;
  logic       bypass_active;

  int errors = 0;
  int checks = 0;

  // Reference model: the current divide period is a queue of per-cycle output levels.
  int wave[$];
  int m_mode  = M_OFF;
  int m_ratio = 0;
  bit m_tick  = 1'b0;
  bit m_byp   = 1'b0;
  bit m_neg   = 1'b0;

  realtime last_t = -1.0;

  clk_div_cfg #(.RATIO_W(8)) dut (
    .ref_clk        (ref_clk),
    .reset          (reset),
    .enable         (enable),
    .division_ratio (division_ratio),
    .divided_clk    (divided_clk),
    .div_tick       (div_tick),
    .ratio_active   (ratio_active),
    .bypass_active  (bypass_active)
  );

  initial begin
    ref_clk = 1'b0;
    forever #HALF ref_clk = ~ref_clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic int level();
    return (m_mode == M_DIV && wave.size() > 0) ? wave[0] : 0;
  endfunction

  function automatic void startPeriod(input int n);
    wave.delete();
    for (int i = 0; i < n; i++) wave.push_back((i < n / 2) ? 1 : 0);
    m_mode  = M_DIV;
    m_tick  = 1'b1;
    m_ratio = n;
  endfunction

  function automatic void modelReset();
    wave.delete();
    m_mode  = M_OFF;
    m_ratio = 0;
    m_tick  = 1'b0;
    m_byp   = 1'b0;
    m_neg   = 1'b0;
  endfunction

  function automatic void modelPosedge(input bit en, input int n);
    m_tick = 1'b0;
    case (m_mode)
      M_OFF: if (en) begin
        if (n >= 2) startPeriod(n);
        else begin m_mode = M_BYP; m_ratio = n; end
      end
      M_DIV: begin
        void'(wave.pop_front());
        if (wave.size() == 0) begin
          if (!en) begin m_mode = M_OFF; m_ratio = 0; end
          else if (n < 2) begin m_mode = M_BYP; m_ratio = n; end
          else startPeriod(n);
        end
      end
      M_BYP: begin
        m_ratio = n;
        if (!en || n >= 2) m_mode = M_LEAVE;
      end
      default: begin
        if (!en) begin m_mode = M_OFF; m_ratio = 0; end
        else if (n >= 2) startPeriod(n);
        else begin m_mode = M_BYP; m_ratio = n; end
      end
    endcase
  endfunction

  // One full ref_clk cycle: drive inputs, check after the posedge and after the negedge.
  task automatic applyStimulus(input bit en, input int n);
    int exp_clk;
    enable         = en;
    division_ratio = 8'(n);
    @(posedge ref_clk);
    modelPosedge(en, n);
    #1;
    exp_clk = m_byp ? 1 : level();
    if (DUTY50 && !m_byp && (m_ratio % 2 == 1) && m_neg) exp_clk = 1;
    checkOutput("clk_hi", 32'(divided_clk), 32'(exp_clk));
    checkOutput("tick", 32'(div_tick), 32'(m_tick));
    checkOutput("ratio", 32'(ratio_active), 32'(m_ratio));
    checkOutput("byp_hi", 32'(bypass_active), 32'(m_byp));
    @(negedge ref_clk);
    m_neg = level() != 0;
    m_byp = m_mode == M_BYP;
    #1;
    checkOutput("clk_lo", 32'(divided_clk), 32'(level()));
    checkOutput("byp_lo", 32'(bypass_active), 32'(m_byp));
  endtask

  // Called right after applyStimulus; asserts and releases reset inside the ref_clk low phase.
  task automatic pulseReset();
    #1 reset = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_clk", 32'(divided_clk), 32'd0);
    checkOutput("rst_tick", 32'(div_tick), 32'd0);
    checkOutput("rst_ratio", 32'(ratio_active), 32'd0);
    checkOutput("rst_byp", 32'(bypass_active), 32'd0);
    #1 reset = 1'b1;
  endtask

  always @(reset) last_t = -1.0;

  // No phase of divided_clk may be shorter than half a ref_clk period.
  always @(divided_clk) begin
    if (reset === 1'b1) begin
      if (last_t >= 0.0) checkOutput("min_phase", 32'(($realtime - last_t) >= HALF), 32'd1);
      last_t = $realtime;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: got no finish by %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    bit en;
    reset          = 1'b1;
    enable         = 1'b0;
    division_ratio = '0;
    #1 reset = 1'b0;
    #2;
    checkOutput("init_clk", 32'(divided_clk), 32'd0);
    checkOutput("init_tick", 32'(div_tick), 32'd0);
    checkOutput("init_ratio", 32'(ratio_active), 32'd0);
    checkOutput("init_byp", 32'(bypass_active), 32'd0);
    @(negedge ref_clk);
    #1 reset = 1'b1;

    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 4);
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, 5);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 4);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 6);
    for (int i = 0; i < 9; i++) applyStimulus(1'b1, 8);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8);
    for (int i = 0; i < 14; i++) applyStimulus(1'b0, 8);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 4);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1);
    for (int i = 0; i < 10; i++) applyStimulus(1'b1, 6);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 6);
    pulseReset();
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 6);

    n  = 3;
    en = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        n = $urandom_range(0, 11);
        if (n > 9) n = $urandom_range(10, 40);
      end
      if ($urandom_range(0, 11) == 0) en = ~en;
      applyStimulus(en, n);
      if ($urandom_range(0, 299) == 0) pulseReset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
